// File: rtl/grid_seq_ctrl_if.sv
// grid_seq_ctrl_if: sample stream, weight memory read port and grid_8 drive
// bundle between grid_seq_ctrl (master) and its surroundings (slave).
interface grid_seq_ctrl_if #(
  parameter int AW = 8
);
  logic          x_valid;
  logic          x_ready;
  logic [7:0]    x_data;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  logic [71:0]   w_rdata;
  logic          grid_rst_n;
  logic          grid_trig;
  logic [7:0]    grid_din;
  logic [7:0]    grid_sign;
  logic [63:0]   grid_win;
  logic [63:0]   grid_bias;
  logic [63:0]   grid_dout;

  modport master (
    input  x_valid, x_data, w_rdata, grid_dout,
    output x_ready, w_rd_en, w_addr,
    output grid_rst_n, grid_trig, grid_din, grid_sign, grid_win, grid_bias
  );

  modport slave (
    output x_valid, x_data, w_rdata, grid_dout,
    input  x_ready, w_rd_en, w_addr,
    input  grid_rst_n, grid_trig, grid_din, grid_sign, grid_win, grid_bias
  );
endinterface

// File: rtl/grid_seq_ctrl.sv
// grid_seq_ctrl: layer-job sequencer for the 8-neuron grid (shared DTC).
// Optional feature: define GRID_SEQ_ABORT_EN to add the abort input.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; grid out of reset
// CLEAR   | grid_rst_n low for one cycle, biases presented
// FETCH   | x_ready high, waiting for one sample; weight word being read
// LOAD    | weight word captured into grid_win/grid_sign
// TRIG    | one-cycle grid_trig pulse
// CONV    | waiting CONV_CYCLES for conversion/accumulation
// SETTLE  | waiting SETTLE_CYCLES after the last conversion
// CAPTURE | grid_dout captured into result
// DONE    | done pulse, result_valid high
module grid_seq_ctrl #(
  parameter int CONV_CYCLES   = 256,
  parameter int SETTLE_CYCLES = 4,
  parameter int AW            = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   n_inputs,
  input  logic [63:0]   bias_in,
  output logic          busy,
  output logic          done,
  output logic [63:0]   result,
  output logic          result_valid,
`ifdef GRID_SEQ_ABORT_EN
  input  logic          abort,
`endif
  grid_seq_ctrl_if.master bus
);

  localparam int CMAX = (CONV_CYCLES > SETTLE_CYCLES) ? CONV_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] CONV_LOAD   = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [AW:0]   MAX_N       = {1'b1, {AW{1'b0}}};

  typedef enum logic [3:0] {
    IDLE, CLEAR, FETCH, LOAD, TRIG, CONV, SETTLE, CAPTURE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   n_q, n_d;
  logic [63:0]   bias_q, bias_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    sign_q, sign_d;
  logic [63:0]   win_q, win_d;
  logic [63:0]   result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          x_ready_q, x_ready_d;
  logic          w_rd_en_q, w_rd_en_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic          trig_q, trig_d;
  logic          grid_rst_n_q, grid_rst_n_d;
  logic          abort_hit;

`ifdef GRID_SEQ_ABORT_EN
  assign abort_hit = abort & busy_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    n_d            = n_q;
    bias_d         = bias_q;
    din_d          = din_q;
    sign_d         = sign_q;
    win_d          = win_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d            = (n_inputs > MAX_N) ? MAX_N : n_inputs;
          bias_d         = bias_in;
          idx_d          = '0;
          result_valid_d = 1'b0;
          state_d        = CLEAR;
        end
      end
      CLEAR: begin
        if (n_q == '0) begin
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.x_valid && x_ready_q) begin
          din_d   = bus.x_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        win_d   = bus.w_rdata[63:0];
        sign_d  = bus.w_rdata[71:64];
        state_d = TRIG;
      end
      TRIG: begin
        cnt_d   = CONV_LOAD;
        state_d = CONV;
      end
      CONV: begin
        if (cnt_q == '0) begin
          if (idx_q == n_q - (AW+1)'(1)) begin
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end else begin
            idx_d   = idx_q + (AW+1)'(1);
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CAPTURE: begin
        result_d       = bus.grid_dout;
        result_valid_d = 1'b1;
        done_d         = 1'b1;
        state_d        = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it.
    // The weight read is issued every FETCH cycle (re-reading the same
    // address while stalled) so the word for the accepted sample is on
    // w_rdata during LOAD, one cycle after the handshake.
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    x_ready_d    = (state_d == FETCH);
    w_rd_en_d    = (state_d == FETCH);
    w_addr_d     = (state_d == FETCH) ? idx_d[AW-1:0] : w_addr_q;
    trig_d       = (state_d == TRIG);
    grid_rst_n_d = (state_d != CLEAR);

    if (abort_hit) begin
      state_d        = IDLE;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      result_valid_d = 1'b0;
      result_d       = result_q;
      x_ready_d      = 1'b0;
      w_rd_en_d      = 1'b0;
      trig_d         = 1'b0;
      grid_rst_n_d   = 1'b0;
    end
  end

  // State and output registers; reset holds the grid in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      n_q            <= '0;
      bias_q         <= '0;
      din_q          <= '0;
      sign_q         <= '0;
      win_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      x_ready_q      <= 1'b0;
      w_rd_en_q      <= 1'b0;
      w_addr_q       <= '0;
      trig_q         <= 1'b0;
      grid_rst_n_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      n_q            <= n_d;
      bias_q         <= bias_d;
      din_q          <= din_d;
      sign_q         <= sign_d;
      win_q          <= win_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      x_ready_q      <= x_ready_d;
      w_rd_en_q      <= w_rd_en_d;
      w_addr_q       <= w_addr_d;
      trig_q         <= trig_d;
      grid_rst_n_q   <= grid_rst_n_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign result_valid   = result_valid_q;
  assign bus.x_ready    = x_ready_q;
  assign bus.w_rd_en    = w_rd_en_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.grid_rst_n = grid_rst_n_q;
  assign bus.grid_trig  = trig_q;
  assign bus.grid_din   = din_q;
  assign bus.grid_sign  = sign_q;
  assign bus.grid_win   = win_q;
  assign bus.grid_bias  = bias_q;

endmodule

// File: tb/tb_grid_seq_ctrl.sv
// tb_grid_seq_ctrl: table-driven and randomized jobs against a fold model
// of the grid; includes a synchronous weight memory and a grid stand-in.
module tb_grid_seq_ctrl;
  localparam int AW     = 4;
  localparam int CONV   = 4;
  localparam int SETTLE = 2;
  localparam int MAXN   = 16;
  localparam int PER    = 3 + CONV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   n_inputs = '0;
  logic [63:0]   bias_in = '0;
  logic          busy, done, result_valid;
  logic [63:0]   result;
`ifdef GRID_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  grid_seq_ctrl_if #(.AW(AW)) bus ();

  grid_seq_ctrl #(.CONV_CYCLES(CONV), .SETTLE_CYCLES(SETTLE), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .n_inputs     (n_inputs),
    .bias_in      (bias_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
`ifdef GRID_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  xs   [2*MAXN];
  logic [71:0] wmem [MAXN];
  logic [63:0] acc;

  // Synchronous weight memory: data one cycle after the read strobe.
  always @(posedge clk) if (bus.w_rd_en) bus.w_rdata <= wmem[bus.w_addr];

  // Grid stand-in: clear loads biases, each trig folds in one sample/weight.
  always @(posedge clk) begin
    if (!bus.grid_rst_n) acc <= bus.grid_bias;
    else if (bus.grid_trig)
      acc <= {acc[55:0], acc[63:56]} ^ bus.grid_win ^ {8{bus.grid_din ^ bus.grid_sign}};
  end
  assign bus.grid_dout = acc;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] b, input int n);
    logic [63:0] a;
    a = b;
    for (int i = 0; i < n; i++)
      a = {a[55:0], a[63:56]} ^ wmem[i][63:0] ^ {8{xs[i] ^ wmem[i][71:64]}};
    return a;
  endfunction

  task automatic run_job(input int n, input int stall_at, input int stall_len,
                         input int mid_start, input bit rnd_gap, input int exp_trigs);
    int cyc, hs, trigs, waits, last_trig, rst_lows, dones, done_cyc, stall_cnt, xr_seen;
    logic        gate;
    logic [63:0] b, exp;
    cyc = 0; hs = 0; trigs = 0; waits = 0; last_trig = 0; rst_lows = 0;
    dones = 0; done_cyc = -1; stall_cnt = 0; xr_seen = 0;
    b = {$urandom, $urandom};
    for (int i = 0; i < 2*MAXN; i++) xs[i] = 8'($urandom);
    for (int i = 0; i < MAXN; i++) wmem[i] = {8'($urandom), $urandom, $urandom};
    exp = model(b, exp_trigs);
    @(negedge clk);
    start = 1'b1; n_inputs = (AW+1)'(n); bias_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3000 && !(dones > 0 && cyc > done_cyc + 2)) begin
      if (!bus.grid_rst_n) rst_lows++;
      if (bus.x_ready) xr_seen++;
      if (bus.grid_trig && trigs < MAXN) begin
        chk("trig_din",  {56'd0, bus.grid_din},  {56'd0, xs[trigs]});
        chk("trig_win",  bus.grid_win,           wmem[trigs][63:0]);
        chk("trig_sign", {56'd0, bus.grid_sign}, {56'd0, wmem[trigs][71:64]});
        if (trigs > 0 && !rnd_gap)
          chk("trig_gap", 64'(cyc - last_trig),
              64'(PER + ((trigs == stall_at) ? stall_len : 0)));
        last_trig = cyc;
      end
      if (bus.grid_trig) trigs++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          done_cyc = cyc;
          chk("done_result", result, exp);
          chk("done_result_valid", {63'd0, result_valid}, 64'd1);
          chk("done_busy", {63'd0, busy}, 64'd0);
        end
      end
      start    = (cyc == mid_start);
      n_inputs = (cyc == mid_start) ? (AW+1)'(7) : (AW+1)'(n);
      bias_in  = (cyc == mid_start) ? ~b : b;
      gate = rnd_gap ? ($urandom_range(0, 2) != 0)
                     : !(hs == stall_at && stall_cnt < stall_len);
      bus.x_valid = gate;
      bus.x_data  = (hs < 2*MAXN) ? xs[hs] : 8'd0;
      if (bus.x_ready && !gate) begin
        waits++;
        if (hs == stall_at) stall_cnt++;
      end
      if (bus.x_ready && gate) begin
        chk("hs_w_rd_en", {63'd0, bus.w_rd_en}, 64'd1);
        chk("hs_w_addr",  {60'd0, bus.w_addr},  64'(hs));
        hs++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.x_valid = 1'b0;
    start = 1'b0;
    chk("done_count",   64'(dones),    64'd1);
    chk("done_latency", 64'(done_cyc), 64'(1 + exp_trigs*PER + SETTLE + 1 + waits));
    chk("trig_count",   64'(trigs),    64'(exp_trigs));
    chk("sample_count", 64'(hs),       64'(exp_trigs));
    chk("clear_pulses", 64'(rst_lows), 64'd1);
    if (n == 0) chk("no_x_ready", 64'(xr_seen), 64'd0);
    if (stall_at >= 0) chk("stall_cycles", 64'(stall_cnt), 64'(stall_len));
    chk("idle_busy",    {63'd0, busy},         64'd0);
    chk("hold_valid",   {63'd0, result_valid}, 64'd1);
    chk("hold_result",  result,                exp);
  endtask

  typedef struct {
    int n;
    int stall_at;
    int stall_len;
    int mid_start;
    int exp_trigs;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{n: 3,  stall_at: -1, stall_len: 0,  mid_start: -1, exp_trigs: 3};
    vecs[1] = '{n: 0,  stall_at: -1, stall_len: 0,  mid_start: -1, exp_trigs: 0};
    vecs[2] = '{n: 4,  stall_at: 1,  stall_len: 10, mid_start: -1, exp_trigs: 4};
    vecs[3] = '{n: 3,  stall_at: -1, stall_len: 0,  mid_start: 5,  exp_trigs: 3};
    vecs[4] = '{n: 1,  stall_at: -1, stall_len: 0,  mid_start: -1, exp_trigs: 1};
    vecs[5] = '{n: 20, stall_at: -1, stall_len: 0,  mid_start: -1, exp_trigs: 16};
    bus.x_valid = 1'b0;
    bus.x_data  = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_grid_rst_n", {63'd0, bus.grid_rst_n}, 64'd0);
    chk("rst_busy",       {63'd0, busy},           64'd0);
    chk("rst_valid",      {63'd0, result_valid},   64'd0);
    chk("rst_result",     result,                  64'd0);
    chk("rst_misc", {57'd0, done, bus.x_ready, bus.w_rd_en, bus.grid_trig, bus.w_addr}, 64'd0);
    chk("rst_grid_bus", bus.grid_win | bus.grid_bias | {48'd0, bus.grid_din, bus.grid_sign}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_grid_rst_n", {63'd0, bus.grid_rst_n}, 64'd1);
    chk("post_rst_busy",       {63'd0, busy},           64'd0);

    foreach (vecs[i])
      run_job(vecs[i].n, vecs[i].stall_at, vecs[i].stall_len, vecs[i].mid_start, 1'b0,
              vecs[i].exp_trigs);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 6));
      run_job(n, -1, 0, -1, 1'b1, n);
    end

    // Asynchronous reset in the middle of a job
    @(negedge clk);
    start = 1'b1; n_inputs = (AW+1)'(3); bias_in = 64'h1234;
    @(posedge clk); #1;
    start = 1'b0; bus.x_valid = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",       {63'd0, busy},           64'd0);
    chk("arst_valid",      {63'd0, result_valid},   64'd0);
    chk("arst_grid_rst_n", {63'd0, bus.grid_rst_n}, 64'd0);
    chk("arst_outs", {62'd0, bus.x_ready, bus.grid_trig}, 64'd0);
    bus.x_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_release_grid_rst_n", {63'd0, bus.grid_rst_n}, 64'd1);
    chk("arst_release_busy",       {63'd0, busy},           64'd0);

`ifdef GRID_SEQ_ABORT_EN
    // Abort during CONV of the second sample of five
    @(negedge clk);
    start = 1'b1; n_inputs = (AW+1)'(5); bias_in = 64'h55;
    @(posedge clk); #1;
    start = 1'b0; bus.x_valid = 1'b1;
    repeat (12) begin
      chk("abort_no_done", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
    end
    chk("abort_pre_busy",  {63'd0, busy},      64'd1);
    chk("abort_pre_trigs", {63'd0, bus.x_ready}, 64'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; bus.x_valid = 1'b0;
    chk("abort_busy",       {63'd0, busy},           64'd0);
    chk("abort_grid_rst_n", {63'd0, bus.grid_rst_n}, 64'd0);
    chk("abort_done",       {63'd0, done},           64'd0);
    chk("abort_valid",      {63'd0, result_valid},   64'd0);
    @(posedge clk); #1;
    chk("abort_grid_rst_n_back", {63'd0, bus.grid_rst_n}, 64'd1);
    chk("abort_valid_hold",      {63'd0, result_valid},   64'd0);
    chk("abort_idle_done",       {63'd0, done},           64'd0);
    run_job(1, -1, 0, -1, 1'b0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
